// File: rtl/ahb_sram_slave.sv
// AHB-Lite subordinate fronting a word-organised data RAM, with configurable
// OKAY wait states and a two-cycle ERROR response for illegal accesses.
module ahb_sram_slave #(
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic [1:0]  htrans,
  input  logic [2:0]  hsize,
  input  logic        hwrite,
  input  logic [31:0] hwdata,
  output logic [31:0] hrdata,
  output logic        hready,
  output logic        hresp,
  output logic [2:0]  fsm_state
);

  // Handshake: a transfer is accepted on a rising edge where hready, hsel and
  // htrans[1] are all 1; its data phase ends on the first edge with hready=1.
  localparam int          AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [29:0] DEPTH_W  = 30'(DEPTH);
  localparam logic [3:0]  WS_LOAD  = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_LAST = 3'd2,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
  } state_t;

  state_t        state;
  logic [3:0]    cnt;
  logic [AW+1:0] addr_q;
  logic [2:0]    size_q;
  logic          write_q;
  logic          hready_q;
  logic          hresp_q;
  logic          accept;
  logic          bad;
  logic [3:0]    be;
  logic [AW-1:0] widx;
  logic [31:0]   mem [DEPTH];
  logic          unused_ok;

  assign unused_ok = htrans[0];
  assign accept    = hready_q & hsel & htrans[1];
  assign widx      = addr_q[AW+1:2];
  assign hready    = hready_q;
  assign hresp     = hresp_q;
  assign fsm_state = state;

  always_comb begin
    bad = 1'b0;
    if (hsize > 3'd2)                                bad = 1'b1;
    if (hsize == 3'd1 && haddr[0])                   bad = 1'b1;
    if (hsize == 3'd2 && haddr[1:0] != 2'b00)        bad = 1'b1;
    if (haddr[31:2] >= DEPTH_W)                      bad = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= 4'd0;
      addr_q   <= '0;
      size_q   <= 3'd0;
      write_q  <= 1'b0;
      hready_q <= 1'b1;
      hresp_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_LAST, ST_ERR2: begin
          if (accept) begin
            addr_q  <= haddr[AW+1:0];
            size_q  <= hsize;
            write_q <= hwrite;
            if (bad) begin
              state    <= ST_ERR1;
              hready_q <= 1'b0;
              hresp_q  <= 1'b1;
            end else if (WAIT_STATES > 0) begin
              state    <= ST_WAIT;
              cnt      <= WS_LOAD;
              hready_q <= 1'b0;
              hresp_q  <= 1'b0;
            end else begin
              state    <= ST_LAST;
              hready_q <= 1'b1;
              hresp_q  <= 1'b0;
            end
          end else begin
            state    <= ST_IDLE;
            hready_q <= 1'b1;
            hresp_q  <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (cnt == 4'd0) begin
            state    <= ST_LAST;
            hready_q <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_ERR1: begin
          state    <= ST_ERR2;
          hready_q <= 1'b1;
          hresp_q  <= 1'b1;
        end
        default: begin
          state    <= ST_IDLE;
          hready_q <= 1'b1;
          hresp_q  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    be = 4'b0000;
    case (size_q)
      3'd0:    be[addr_q[1:0]] = 1'b1;
      3'd1:    be = addr_q[1] ? 4'b1100 : 4'b0011;
      3'd2:    be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  // Write data arrives in the final data-phase cycle, so commit on the edge leaving LAST.
  always_ff @(posedge clk) begin
    if (!rst && state == ST_LAST && write_q) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[widx][8*b +: 8] <= hwdata[8*b +: 8];
      end
    end
  end

  assign hrdata = (state == ST_LAST) ? mem[widx] : 32'h0;

endmodule

// File: doc/ahb_sram_slave.md
# ahb_sram_slave

AHB-Lite subordinate that fronts a word-organised on-chip data RAM and answers the core's `ahb_master` load/store traffic. It sits on the far side of the top-level `haddr/hsize/htrans/hwdata/hwrite/hrdata/hready` bus as the single target for data accesses. It supports:
- byte, halfword and word writes;
- a configurable number of wait states;
- a two-cycle ERROR response for illegal accesses.

## Interface
Parameters:
- `DEPTH`, 1024: RAM size in 32-bit words; legal byte addresses are 0 .. DEPTH*4-1.
- `WAIT_STATES`, 1: hready-low cycles inserted in every OKAY data phase; range 0..15.

Ports:
- `clk`  in  1  clock; all state changes on its rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `hsel`  in  1  slave select; tie to 1 when this is the only target.
- `haddr`  in  32  byte address, address phase.
- `htrans`  in  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- `hsize`  in  3  0 byte, 1 halfword, 2 word; 3..7 illegal.
- `hwrite`  in  1  1 write, 0 read.
- `hwdata`  in  32  write data, data phase, little-endian lanes.
- `hrdata`  out  32  read data, data phase.
- `hready`  out  1  1 = data phase completes this cycle / address phase accepted.
- `hresp`  out  1  0 OKAY, 1 ERROR.

## Operation
- **Transfer acceptance.** A transfer is accepted on an edge where `hready`=1, `hsel`=1 and `htrans[1]`=1. On acceptance, latch `haddr`, `hsize` and `hwrite`.
- **Non-transfers.** IDLE, BUSY, or `hsel`=0 give a zero-wait OKAY and have no effect.
- **Error conditions.** An accepted transfer is an error if any of the following hold:
  - `hsize`>2;
  - halfword with `haddr[0]`=1;
  - word with `haddr[1:0]`≠0;
  - `haddr[31:2]` ≥ DEPTH.
- **State machine.** States are IDLE, WAIT, LAST, ERR1, ERR2.
  - `hready`=1 in IDLE, LAST and ERR2.
  - `hready`=0 in WAIT and ERR1.
  - `hresp`=1 only in ERR1 and ERR2.
- **Transitions.**
  - From IDLE, LAST or ERR2:
    - on an accepted error → ERR1;
    - on an accepted legal transfer → WAIT (counter loaded with WAIT_STATES-1) if WAIT_STATES>0, else LAST;
    - otherwise → IDLE.
  - WAIT: decrement the counter; when the counter is 0 → LAST.
  - ERR1 → ERR2, always. Errors ignore WAIT_STATES.
- **Writes.**
  - Commit on the edge that ends LAST, using the current `hwdata`.
  - Byte enables are decoded from the latched `hsize` and `addr[1:0]`: byte enables lane addr[1:0]; halfword enables lanes {addr[1],0} and {addr[1],1}; word enables all four lanes.
  - Unselected lanes are unchanged.
- **Reads.**
  - In LAST, `hrdata` = mem[addr_q[31:2]], driven combinationally: the full aligned word, with lane extraction done by the master.
  - In every other state `hrdata` = 0.
- **Error transfers.** Never modify memory; `hrdata`=0 throughout.
- **Memory contents.** Not cleared by reset and undefined until written.

## Timing
- **Reset values.** `hready`=1, `hresp`=0, `hrdata`=0, state IDLE, counter 0.
- **Reset mid-operation.** `rst` high on any edge returns to IDLE at that edge. A pending write is discarded and memory is unchanged.
- **Data-phase length.** An OKAY data phase lasts WAIT_STATES+1 cycles.
- **Error-phase length.** An ERROR data phase lasts exactly 2 cycles.
- **Pipelining.** The next address phase overlaps the final data-phase cycle (LAST or ERR2). Back-to-back transfers therefore run with no idle cycle.
- **Write-then-read, same address.** The write commits at the edge ending LAST, so the following read data phase returns the new data; no stall or bypass is needed.
- **Address-phase signals during wait cycles.** Ignored while `hready`=0.

## Test plan
- **Word round trip.** WAIT_STATES=1: NONSEQ word write 0xDEADBEEF to 0x10, then word read of 0x10.
  - Each data phase has exactly one `hready`=0 cycle.
  - Read returns `hrdata`=0xDEADBEEF with `hresp`=0.
- **Byte lanes.** Word write 0x11223344 to 0x0; byte write to 0x2 with `hwdata`=0x00AA0000; read 0x0 → 0x11AA3344. Then halfword write to 0x2 with `hwdata`=0xBEEF0000; read → 0xBEEF3344.
- **Zero-wait pipelining.** WAIT_STATES=0: back-to-back pipelined write 0x12345678 to 0x20 followed immediately by a read of 0x20.
  - `hready` stays 1 throughout.
  - Read data phase returns 0x12345678.
- **Misaligned word read.** Word read of 0x6.
  - Cycle 1: `hready`=0, `hresp`=1.
  - Cycle 2: `hready`=1, `hresp`=1.
  - `hrdata`=0 throughout.
  - Then a misaligned halfword write to 0x21 with `hwdata`=0xFFFFFFFF gets the same response; read 0x20 still returns 0x12345678.
- **Other errors and non-transfers.** DEPTH=1024: access to 0x1000 → ERROR. Word access with `hsize`=3 → ERROR. `htrans`=BUSY or `hsel`=0 → single-cycle OKAY with no memory change.
- **Reset during a write.** WAIT_STATES=3: issue word write 0xCAFEF00D to 0x40; assert `rst` during the second WAIT cycle.
  - Next cycle: `hready`=1, `hresp`=0.
  - Read of 0x40 returns its previous value.
